// File: rtl/alu_pc_unit.sv
// Combinational 16-bit ALU (add/sub/mul/div/logic/shift with N/Z/C flags)
// plus a program counter register with load and increment.
module alu_pc_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             pc_write,
  input  logic [WIDTH-1:0] pc_data,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_hi,
  output logic [2:0]       flags,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_inc
);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_DIV = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  // Bit-serial ripple-carry adder; returns {carry_out, sum}.
  function automatic logic [WIDTH:0] rca(input logic [WIDTH-1:0] x,
                                         input logic [WIDTH-1:0] y,
                                         input logic             cin);
    logic             c;
    logic [WIDTH-1:0] s;
    c = cin;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  logic             is_sub;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   add_res;
  logic [2*WIDTH-1:0] prod;
  logic [3:0]       sh_amt;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH-1:0] shr_res;
  logic             carry;

  // Subtraction reuses the adder as a + ~b + 1; its carry_out is the no-borrow flag.
  assign is_sub  = (op == OP_SUB);
  assign add_b   = is_sub ? ~b : b;
  assign add_res = rca(a, add_b, is_sub);

  assign prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign sh_amt  = b[3:0];
  // The extra top bit catches the last bit shifted out of a (zero when sh_amt is 0).
  assign shl_ext = {1'b0, a} << sh_amt;
  assign shr_res = a >> sh_amt;

  always_comb begin
    alu_out = '0;
    alu_hi  = '0;
    carry   = 1'b0;
    case (op)
      OP_NOP: begin
        alu_out = '0;
      end
      OP_ADD, OP_SUB: begin
        alu_out = add_res[WIDTH-1:0];
        carry   = add_res[WIDTH];
      end
      OP_MUL: begin
        alu_out = prod[WIDTH-1:0];
        alu_hi  = prod[2*WIDTH-1:WIDTH];
        carry   = |prod[2*WIDTH-1:WIDTH];
      end
      OP_AND: alu_out = a & b;
      OP_OR:  alu_out = a | b;
      OP_XOR: alu_out = a ^ b;
      OP_DIV: begin
        if (b == '0) begin
          alu_out = '1;
          alu_hi  = a;
        end else begin
          alu_out = a / b;
          alu_hi  = a % b;
        end
      end
      OP_SHL: begin
        alu_out = shl_ext[WIDTH-1:0];
        carry   = shl_ext[WIDTH];
      end
      OP_SHR: alu_out = shr_res;
      default: begin
        alu_out = '0;
        alu_hi  = '0;
        carry   = 1'b0;
      end
    endcase
  end

  assign flags = {alu_out[WIDTH-1], (alu_out == '0), carry};

  // Same adder structure computes pc + 1; the carry out is dropped so it wraps.
  assign pc_inc = WIDTH'(rca(pc, WIDTH'(1), 1'b0));

  always_ff @(posedge clk) begin
    if (clear)
      pc <= '0;
    else if (pc_write)
      pc <= pc_data;
    else
      pc <= pc_inc;
  end

endmodule

// File: tb/tb_alu_pc_unit.sv
// Directed bench for alu_pc_unit: PC sequencing/priority and ALU vectors.
module tb_alu_pc_unit;

  logic        clk;
  logic        clear;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        pc_write;
  logic [15:0] pc_data;
  logic [15:0] alu_out;
  logic [15:0] alu_hi;
  logic [2:0]  flags;
  logic [15:0] pc;
  logic [15:0] pc_inc;

  int total;
  int passed;

  alu_pc_unit #(.WIDTH(16)) dut (
    .clk      (clk),
    .clear    (clear),
    .op       (op),
    .a        (a),
    .b        (b),
    .pc_write (pc_write),
    .pc_data  (pc_data),
    .alu_out  (alu_out),
    .alu_hi   (alu_hi),
    .flags    (flags),
    .pc       (pc),
    .pc_inc   (pc_inc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic alu(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    op = o;
    a  = x;
    b  = y;
    #1;
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    clear    = 1'b1;
    pc_write = 1'b0;
    pc_data  = 16'h0000;
    op       = 4'd0;
    a        = 16'h0000;
    b        = 16'h0000;

    // Reset, then free-running count
    @(negedge clk);
    check("pc_reset", pc, 16'h0000);
    check("pc_inc_reset", pc_inc, 16'h0001);
    clear = 1'b0;
    @(negedge clk);
    check("pc_cnt1", pc, 16'h0001);
    check("pc_inc_cnt1", pc_inc, 16'h0002);
    @(negedge clk);
    check("pc_cnt2", pc, 16'h0002);
    check("pc_inc_cnt2", pc_inc, 16'h0003);
    @(negedge clk);
    check("pc_cnt3", pc, 16'h0003);
    check("pc_inc_cnt3", pc_inc, 16'h0004);

    // Load and wrap
    pc_write = 1'b1;
    pc_data  = 16'hFFFE;
    @(negedge clk);
    check("pc_load", pc, 16'hFFFE);
    check("pc_inc_load", pc_inc, 16'hFFFF);
    pc_write = 1'b0;
    @(negedge clk);
    check("pc_ffff", pc, 16'hFFFF);
    check("pc_inc_wrap", pc_inc, 16'h0000);
    @(negedge clk);
    check("pc_wrap", pc, 16'h0000);

    // Load a mid value, count, then clear mid-count
    pc_write = 1'b1;
    pc_data  = 16'h1230;
    @(negedge clk);
    pc_write = 1'b0;
    @(negedge clk);
    check("pc_load_cnt", pc, 16'h1231);
    clear = 1'b1;
    @(negedge clk);
    check("pc_clear_mid", pc, 16'h0000);

    // Clear beats pc_write
    pc_write = 1'b1;
    pc_data  = 16'hBEEF;
    @(negedge clk);
    check("pc_clear_prio", pc, 16'h0000);
    clear = 1'b0;
    @(negedge clk);
    check("pc_write_prio", pc, 16'hBEEF);
    pc_write = 1'b0;

    // ALU vectors
    alu(4'd1, 16'hFFFF, 16'h0001);
    check("add_out", alu_out, 16'h0000);
    check("add_hi", alu_hi, 16'h0000);
    check("add_flags", {13'd0, flags}, 16'h0003);
    alu(4'd1, 16'h1234, 16'h1111);
    check("add2_out", alu_out, 16'h2345);
    check("add2_flags", {13'd0, flags}, 16'h0000);
    alu(4'd2, 16'h0003, 16'h0005);
    check("sub_out", alu_out, 16'hFFFE);
    check("sub_flags", {13'd0, flags}, 16'h0004);
    alu(4'd2, 16'h0007, 16'h0007);
    check("sub_eq_flags", {13'd0, flags}, 16'h0003);
    alu(4'd3, 16'h1234, 16'h0100);
    check("mul_out", alu_out, 16'h3400);
    check("mul_hi", alu_hi, 16'h0012);
    check("mul_flags", {13'd0, flags}, 16'h0001);
    alu(4'd3, 16'h00FF, 16'h0002);
    check("mul_small_flags", {13'd0, flags}, 16'h0000);
    alu(4'd4, 16'hF0F0, 16'hFF00);
    check("and_out", alu_out, 16'hF000);
    check("and_flags", {13'd0, flags}, 16'h0004);
    alu(4'd5, 16'h0F00, 16'h00F0);
    check("or_out", alu_out, 16'h0FF0);
    alu(4'd6, 16'hA5A5, 16'hA5A5);
    check("xor_out", alu_out, 16'h0000);
    check("xor_flags", {13'd0, flags}, 16'h0002);
    alu(4'd7, 16'd100, 16'd7);
    check("div_out", alu_out, 16'd14);
    check("div_hi", alu_hi, 16'd2);
    alu(4'd7, 16'd100, 16'd0);
    check("div0_out", alu_out, 16'hFFFF);
    check("div0_hi", alu_hi, 16'd100);
    check("div0_flags", {13'd0, flags}, 16'h0004);
    alu(4'd8, 16'h8001, 16'h0001);
    check("shl_out", alu_out, 16'h0002);
    check("shl_flags", {13'd0, flags}, 16'h0001);
    alu(4'd8, 16'h0001, 16'hFFF4);
    check("shl_mask_out", alu_out, 16'h0010);
    check("shl_mask_flags", {13'd0, flags}, 16'h0000);
    alu(4'd8, 16'h8001, 16'h0000);
    check("shl0_flags", {13'd0, flags}, 16'h0004);
    alu(4'd9, 16'h8000, 16'h00F3);
    check("shr_out", alu_out, 16'h1000);
    check("shr_flags", {13'd0, flags}, 16'h0000);
    alu(4'd0, 16'h1234, 16'h5678);
    check("nop_out", alu_out, 16'h0000);
    check("nop_hi", alu_hi, 16'h0000);
    check("nop_flags", {13'd0, flags}, 16'h0002);
    alu(4'd12, 16'hFFFF, 16'h0003);
    check("op12_out", alu_out, 16'h0000);
    check("op12_hi", alu_hi, 16'h0000);
    check("op12_flags", {13'd0, flags}, 16'h0002);

    // clear has no effect on the combinational ALU
    clear = 1'b1;
    alu(4'd1, 16'h0002, 16'h0003);
    check("alu_under_clear", alu_out, 16'h0005);
    clear = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_pc_unit.md
ALU_PC_UNIT -- requirements
Module: alu_pc_unit

Interface
REQ-001 Parameter: WIDTH, 16, datapath width; all requirements are stated for WIDTH=16, the only supported value.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clear  input  1  reset; synchronous, active-high.
REQ-004 op  input  4  ALU operation select.
REQ-005 a  input  16  ALU operand A.
REQ-006 b  input  16  ALU operand B.
REQ-007 pc_write  input  1  load program counter from pc_data at next edge.
REQ-008 pc_data  input  16  program counter load value.
REQ-009 alu_out  output  16  ALU primary result, combinational.
REQ-010 alu_hi  output  16  ALU secondary result (multiply high word / remainder), combinational.
REQ-011 flags  output  3  {negative, zero, carry}, combinational.
REQ-012 pc  output  16  program counter register value.
REQ-013 pc_inc  output  16  pc + 1 modulo 2^16, combinational.

Function
REQ-014 One internal 16-bit ripple-carry adder (A, B, carry_in -> sum, carry_out) SHALL serve ADD, SUB (A + ~B + 1) and pc_inc (pc + 1, carry_in 0).
REQ-015 op decode: 0 NOP (alu_out=0, alu_hi=0); 1 ADD; 2 SUB (a-b); 3 MUL unsigned; 4 AND; 5 OR; 6 XOR; 7 DIV unsigned; 8 SHL logical; 9 SHR logical; 10-15 alu_out=0, alu_hi=0.
REQ-016 ADD/SUB: alu_out = low 16 bits; wrap modulo 2^16; alu_hi=0.
REQ-017 MUL: 32-bit product of a*b; alu_out = product[15:0], alu_hi = product[31:16].
REQ-018 DIV: alu_out = a / b, alu_hi = a % b; b=0 -> alu_out=16'hFFFF, alu_hi=a.
REQ-019 AND/OR/XOR: bitwise; alu_hi=0.
REQ-020 SHL/SHR: shift a by b[3:0] (0-15), zero fill; b[15:4] ignored; alu_hi=0.
REQ-021 flags[0] carry: ADD -> adder carry_out; SUB -> 1 when a >= b unsigned (no borrow); MUL -> 1 when alu_hi != 0; SHL -> last bit shifted out (0 when shift amount 0); all other ops 0.
REQ-022 flags[1] zero: 1 when alu_out == 0, for every op including NOP.
REQ-023 flags[2] negative: alu_out[15], for every op.
REQ-024 ALU outputs SHALL be purely combinational, zero latency, independent of clk and clear.
REQ-025 pc at each rising edge: clear=1 -> 0; else pc_write=1 -> pc_data; else pc + 1.
REQ-026 Priority: clear over pc_write over increment.
REQ-027 pc wrap: 16'hFFFF increments to 16'h0000; pc_inc for 16'hFFFF is 16'h0000.
REQ-028 pc_inc SHALL track pc combinationally; no extra cycle of latency.

Reset
REQ-029 clear sampled only at rising clk; asserted -> pc = 0 after that edge, pc_inc = 1.
REQ-030 clear asserted mid-count or concurrently with pc_write SHALL still force pc = 0.
REQ-031 Before first reset pc is undefined; no other state exists in the block.
REQ-032 clear has no effect on alu_out, alu_hi, flags.

Verification
REQ-033 clear=1 one edge, then clear=0, pc_write=0 three edges -> pc sequence 0,1,2,3; pc_inc 1,2,3,4.
REQ-034 pc_write=1, pc_data=16'hFFFE, one edge then pc_write=0 two edges -> pc FFFE, FFFF, 0000; clear+pc_write=1 together -> pc 0.
REQ-035 op=1, a=16'hFFFF, b=1 -> alu_out 0, flags 3'b011; op=2, a=3, b=5 -> alu_out 16'hFFFE, flags 3'b100.
REQ-036 op=3, a=16'h1234, b=16'h0100 -> alu_out 16'h3400, alu_hi 16'h0012, carry 1; op=7, a=100, b=7 -> alu_out 14, alu_hi 2; b=0 -> alu_out FFFF, alu_hi 100.
REQ-037 op=8, a=16'h8001, b=1 -> alu_out 16'h0002, carry 1; op=9, a=16'h8000, b=16'h00F3 -> alu_out 16'h1000; op=6, a=b=16'hA5A5 -> alu_out 0, zero 1.
REQ-038 op=0 and op=12 with arbitrary a, b -> alu_out 0, alu_hi 0, flags 3'b010.
